// File: rtl/uart_pkg.sv
// Shared UART scope definitions: launch FSM encoding, byte width and the
// baud-select codes common to uart_byte_tx and uart_byte_rx.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer-side write/status signals and transmitter-side launch handshake
// of uart_tx_buffer; slave is the buffer, master is whoever drives it.
interface uart_tx_buffer_if #(
  parameter int ADDR_W = 4
) ();
  import uart_pkg::*;

  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              ovf_clr;
  logic              byte_en;
  logic [BYTE_W-1:0] data_byte;
  logic              tx_done;
  logic              busy;

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_done,
    output full, empty, level, overflow, byte_en, data_byte, busy
  );

  modport master (
    output wr_en, wr_data, ovf_clr, tx_done,
    input  full, empty, level, overflow, byte_en, data_byte, busy
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered level/full/empty flags.
// A write to a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [7:0]        wr_data,
  input  logic              rd,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_nxt;
  logic              full_q;
  logic              empty_q;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_ok = rd && !empty_q;
  assign wr_ok = wr && (!full_q || rd_ok);

  always_comb begin
    level_nxt = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_FULL);
      empty_q <= (level_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;
endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and launch pacer in front of uart_byte_tx.
// Define UART_TX_BUF_GAP_EN to compile in the GAP_CYCLES inter-byte pause.
module uart_tx_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_buffer_if.slave bus
);
  import uart_pkg::*;

  // IDLE: wait for data | LAUNCH: pop head, pulse byte_en | WAIT: for tx_done | GAP: pacing pause

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
    $error("uart_tx_buffer: DEPTH must equal 2**ADDR_W");
  end
  if (GAP_CYCLES < 0) begin : g_gap_chk
    $error("uart_tx_buffer: GAP_CYCLES must be non-negative");
  end

  tx_state_t         state;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_level;
  logic [BYTE_W-1:0] head;
  logic              pop;
  logic              wr_drop;
  logic              byte_en_q;
  logic              busy_q;
  logic              ovf_q;
  logic [BYTE_W-1:0] data_q;

`ifdef UART_TX_BUF_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  logic [GAP_W-1:0] gap_cnt;
`endif

  // LAUNCH is only entered with a non-empty FIFO, so pop is always honoured.
  assign pop     = (state == ST_LAUNCH);
  assign wr_drop = bus.wr_en && fifo_full && !pop;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd      (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_en_q <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
`ifdef UART_TX_BUF_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      byte_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state  <= ST_LAUNCH;
            busy_q <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          data_q    <= head;
          byte_en_q <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
`ifdef UART_TX_BUF_GAP_EN
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
`else
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
`ifdef UART_TX_BUF_GAP_EN
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A fresh overflow outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)              ovf_q <= 1'b0;
    else if (wr_drop)     ovf_q <= 1'b1;
    else if (bus.ovf_clr) ovf_q <= 1'b0;
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.level     = fifo_level;
  assign bus.overflow  = ovf_q;
  assign bus.byte_en   = byte_en_q;
  assign bus.data_byte = data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: vector table, directed corner
// sequences and randomized streaming against a queue-based reference model.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int GAP_CYCLES = 10;
`ifdef UART_TX_BUF_GAP_EN
  localparam int GAP_ADD = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam bit GAP_EN  = 1'b1;
`else
  localparam int GAP_ADD = 0;
  localparam bit GAP_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endfunction

  // Reference model: a byte queue plus edge-numbered launch bookkeeping.
  logic [7:0] m_q[$];
  logic [7:0] sent_q[$];
  bit         m_valid = 1'b0;
  bit         m_wait;
  int         m_idle_at;
  int         m_launch_at;
  bit         m_ovf;
  bit         m_be;
  bit         m_busy;
  logic [7:0] m_data;

  function automatic void model_step(int e);
    bit ovf_set;
    if (rst) begin
      m_q.delete();
      m_wait      = 1'b0;
      m_idle_at   = e;
      m_launch_at = -1;
      m_ovf       = 1'b0;
      m_be        = 1'b0;
      m_data      = 8'h00;
      m_valid     = 1'b1;
    end else begin
      m_be = 1'b0;
      if (m_wait && bus.tx_done) begin
        m_wait    = 1'b0;
        m_idle_at = e + GAP_ADD;
      end
      if (m_launch_at == e) begin
        m_data      = m_q.pop_front();
        m_be        = 1'b1;
        m_wait      = 1'b1;
        m_launch_at = -1;
      end
      ovf_set = 1'b0;
      if (bus.wr_en) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.wr_data);
        else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      if (!m_wait && m_launch_at < 0 && e >= m_idle_at && m_q.size() > 0)
        m_launch_at = e + 2;
    end
    m_busy = !(!m_wait && e >= m_idle_at && (m_launch_at < 0 || e < m_launch_at - 1));
  endfunction

  always @(posedge clk) begin
    cyc++;
    model_step(cyc);
    #2;
    if (m_valid) begin
      chk("mon_byte_en",   int'(bus.byte_en),   int'(m_be));
      chk("mon_data_byte", int'(bus.data_byte), int'(m_data));
      chk("mon_busy",      int'(bus.busy),      int'(m_busy));
      chk("mon_level",     int'(bus.level),     m_q.size());
      chk("mon_full",      int'(bus.full),      int'(m_q.size() == DEPTH));
      chk("mon_empty",     int'(bus.empty),     int'(m_q.size() == 0));
      chk("mon_overflow",  int'(bus.overflow),  int'(m_ovf));
      if (bus.byte_en) sent_q.push_back(bus.data_byte);
    end
  end

  task automatic drive(bit r, bit w, logic [7:0] d, bit dn, bit c);
    rst         = r;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.tx_done = dn;
    bus.ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(output int edge_no, output logic [7:0] b);
    bit ok = 1'b0;
    edge_no = -1;
    b = 8'h00;
    for (int i = 0; i < 60 && !ok; i++) begin
      drive(0, 0, 8'h00, 0, 0);
      if (bus.byte_en) begin
        ok = 1'b1;
        edge_no = cyc;
        b = bus.data_byte;
      end
    end
    if (!ok) chk("launch_timeout", 0, 1);
  endtask

  typedef struct {
    bit r; bit w; logic [7:0] d; bit dn; bit c;
    bit be; logic [7:0] db; bit busy; bit full; bit empty; int lvl; bit ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          t_edge, l_edge, e0, n0, dly;
    logic [7:0]  b;

    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_done = 1'b0; bus.ovf_clr = 1'b0;

    tbl[0] = '{1,0,8'h00,0,0, 0,8'h00,0,0,1,0,0};
    tbl[1] = '{0,0,8'h00,1,0, 0,8'h00,0,0,1,0,0};
    tbl[2] = '{0,1,8'hA5,0,0, 0,8'h00,0,0,0,1,0};
    tbl[3] = '{0,0,8'h00,0,0, 0,8'h00,1,0,0,1,0};
    tbl[4] = '{0,0,8'h00,0,0, 1,8'hA5,1,0,1,0,0};
    tbl[5] = '{0,0,8'h00,0,0, 0,8'hA5,1,0,1,0,0};
    tbl[6] = '{0,1,8'h3C,0,0, 0,8'hA5,1,0,0,1,0};
    tbl[7] = '{0,0,8'h00,1,0, 0,8'hA5,GAP_EN,0,0,1,0};
    tbl[8] = '{0,0,8'h00,0,1, 0,8'hA5,1,0,0,1,0};

    drive(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].dn, tbl[i].c);
      chk("tbl_byte_en",   int'(bus.byte_en),   int'(tbl[i].be));
      chk("tbl_data_byte", int'(bus.data_byte), int'(tbl[i].db));
      chk("tbl_busy",      int'(bus.busy),      int'(tbl[i].busy));
      chk("tbl_full",      int'(bus.full),      int'(tbl[i].full));
      chk("tbl_empty",     int'(bus.empty),     int'(tbl[i].empty));
      chk("tbl_level",     int'(bus.level),     tbl[i].lvl);
      chk("tbl_overflow",  int'(bus.overflow),  int'(tbl[i].ovf));
    end

    // Single byte: launch exactly two edges after the write.
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h5A, 0, 0);
    e0 = cyc;
    drive(0, 1, 8'hC3, 0, 0);
    wait_launch(l_edge, b);
    chk("first_latency", l_edge - e0, 2);
    chk("first_data", int'(b), 8'h5A);
    drive(0, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    t_edge = cyc;
    wait_launch(l_edge, b);
    chk("launch_spacing", l_edge - t_edge, 2 + GAP_ADD);
    chk("second_data", int'(b), 8'hC3);

    // Burst to full, overflow, set-beats-clear, write coinciding with pop.
    drive(1, 0, 8'h00, 0, 0);
    sent_q.delete();
    for (int i = 1; i <= 17; i++) drive(0, 1, 8'(i), 0, 0);
    chk("burst_full", int'(bus.full), 1);
    chk("burst_level", int'(bus.level), 16);
    chk("burst_no_ovf", int'(bus.overflow), 0);
    drive(0, 1, 8'hFF, 0, 0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_level", int'(bus.level), 16);
    drive(0, 1, 8'hFF, 0, 1);
    chk("ovf_set_wins", int'(bus.overflow), 1);
    drive(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", int'(bus.overflow), 0);
    drive(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < GAP_ADD + 1; i++) drive(0, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h12, 0, 0);
    chk("pop_write_launch", int'(bus.byte_en), 1);
    chk("pop_write_level", int'(bus.level), 16);
    chk("pop_write_no_ovf", int'(bus.overflow), 0);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      wait_launch(l_edge, b);
    end
    drive(0, 0, 8'h00, 1, 0);
    chk("burst_count", sent_q.size(), 18);
    for (int i = 0; i < 18 && i < sent_q.size(); i++)
      chk("burst_order", int'(sent_q[i]), i + 1);

    // Reset while waiting with five bytes queued, then a stray tx_done.
    drive(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 8'h40 + 8'(i), 0, 0);
    chk("rst_pre_level", int'(bus.level), 5);
    chk("rst_pre_busy", int'(bus.busy), 1);
    drive(1, 0, 8'h00, 0, 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_byte_en", int'(bus.byte_en), 0);
    chk("rst_data", int'(bus.data_byte), 0);
    n0 = sent_q.size();
    drive(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 8'h00, 0, 0);
    chk("stray_done_launches", sent_q.size(), n0);
    chk("stray_done_busy", int'(bus.busy), 0);

    // Randomized streaming with a behavioural transmitter.
    drive(1, 0, 8'h00, 0, 0);
    sent_q.delete();
    dly = 0;
    for (int i = 0; i < 1200; i++) begin
      bit w, dn, c;
      w  = (i % 400 < 250) ? ($urandom % 3 != 0) : ($urandom % 4 == 0);
      dn = (dly == 1) || ($urandom % 20 == 0);
      c  = ($urandom % 8 == 0);
      if (dly > 0) dly--;
      drive(0, w, 8'($urandom), dn, c);
      if (bus.byte_en) dly = $urandom_range(1, 5);
    end
    chk("rand_launches", int'(sent_q.size() >= 40), 1);

    drive(0, 0, 8'h00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
